// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the buses that the instruction fetch unit sits between: the
//   instruction-memory read port, the valid/ready handshake to decode, and the
//   redirect request from the core. clk and reset stay plain module ports.
//
//   Signals
//     imem_req     fetch -> imem   read request this cycle (always accepted)
//     imem_addr    fetch -> imem   word-aligned read address
//     imem_rvalid  imem  -> fetch  read data valid, in-order responses
//     imem_rdata   imem  -> fetch  read data
//     instr_valid  fetch -> decode head of prefetch queue is valid
//     instr_ready  decode-> fetch  decode takes the head this cycle
//     instr        fetch -> decode head instruction word
//     instr_pc     fetch -> decode address of the head instruction
//     redirect     core  -> fetch  taken branch/jump (pcsrc | jump)
//     redirect_pc  core  -> fetch  branch/jump target, bits [1:0] ignored
//
//   Modports
//     master  the fetch unit
//     slave   the surrounding core / memory / testbench
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch front-end for the MIPS core. Holds the PC, issues in-order
//   word reads to instruction memory, buffers returned words in a prefetch FIFO
//   and hands them to decode over a valid/ready handshake. A redirect (taken
//   beq/ble/jump) flushes the FIFO, discards responses still in flight and
//   restarts fetch at the new target.
//
//   Parameters
//     DEPTH     prefetch FIFO entries and maximum outstanding reads (power of 2, >= 2)
//     RESET_PC  PC loaded on reset
//
//   Ports
//     clk    core clock, all state updates on posedge
//     reset  synchronous, active-high
//     bus    instr_fetch_unit_if.master: imem read port, decode handshake, redirect
//
//   Build option
//     FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is empty
//                      (and not being dropped) is presented to decode in the same
//                      cycle; if decode accepts it, it never enters the FIFO.
//                      When undefined, every response is pushed first and decode
//                      sees it one cycle after imem_rvalid.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_X = DEPTH[CW:0];

    // Architectural state
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;

    // Prefetch FIFO payload and the in-order address tags of outstanding reads
    logic [31:0] data_mem [DEPTH];
    logic [31:0] addr_mem [DEPTH];
    logic [31:0] tag_mem  [DEPTH];

    logic        issue;
    logic        accept;
    logic        bypass_hit;
    logic        push;
    logic        fifo_pop;
    logic [CW:0] credit_used;
    logic [31:0] rsp_addr;

    // A request needs a slot reserved for its response; slots held by words
    // already in the FIFO or still in flight both count, and a pop in the same
    // cycle does not release one.
    assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue       = !reset && !bus.redirect && (credit_used < DEPTH_X);

    // The oldest outstanding tag always belongs to the response arriving now.
    assign rsp_addr = tag_mem[tag_rd_q];
    assign accept   = !reset && bus.imem_rvalid && (drop_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = accept && (count_q == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word consumed by decode never touches the FIFO.
    assign push     = accept && !(bypass_hit && bus.instr_ready);
    assign fifo_pop = bus.instr_valid && bus.instr_ready && !bypass_hit;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;

    // NOTE: every output is given a value on every path, so no latch is inferred.
    always_comb begin
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.instr_pc    = 32'h0;
        if (reset) begin
            bus.instr_valid = 1'b0;
        end else if (bypass_hit) begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.imem_rdata;
            bus.instr_pc    = rsp_addr;
        end else begin
            bus.instr_valid = (count_q != '0);
            bus.instr       = data_mem[rd_ptr_q];
            bus.instr_pc    = addr_mem[rd_ptr_q];
        end
    end

    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        inflight_d = inflight_q + CW'(issue) - CW'(bus.imem_rvalid);

        // The tag queue tracks every outstanding read, dropped or not, so it
        // is never flushed; it drains naturally as stale responses arrive.
        if (issue) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_wr_q + AW'(1);
        end
        if (bus.imem_rvalid) begin
            tag_rd_d = tag_rd_q + AW'(1);
        end

        if (bus.redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d     = bus.redirect_pc & ~32'h3;
            drop_d   = inflight_q - CW'(bus.imem_rvalid);
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (bus.imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(fifo_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // NOTE: the storage arrays are not reset; the counters and pointers decide
    // which entries are live, so their contents after reset never matter.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (push && !bus.redirect) begin
            data_mem[wr_ptr_q] <= bus.imem_rdata;
            addr_mem[wr_ptr_q] <= rsp_addr;
        end
    end

    // The credit check guarantees a free slot for every response.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == DEPTH_C) && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int LAT0 = 0;   // rvalid-to-instr_valid latency
`else
    localparam int LAT0 = 1;
`endif
    localparam int NLOG = 64;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_unit_if bus_if ();

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        imem_q[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_instr[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 1;

    logic        rst, ready, redir;
    logic [31:0] redir_pc;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    logic        log_req    [NLOG];
    logic [31:0] log_addr   [NLOG];
    logic        log_valid  [NLOG];
    logic [31:0] log_pc     [NLOG];
    logic        log_rvalid [NLOG];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < NLOG; i++) begin
            log_req[i]    = 1'b0;
            log_addr[i]   = 32'h0;
            log_valid[i]  = 1'b0;
            log_pc[i]     = 32'h0;
            log_rvalid[i] = 1'b0;
        end
        acc_pc.delete();
        acc_instr.delete();
    endtask

    // One clock cycle: drive inputs on the falling edge (imem model included),
    // sample outputs 1 time unit later, well away from the rising edge.
    task automatic cycle();
        req_t r;
        @(negedge clk);
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        if (rst) begin
            imem_q.delete();
        end else if (imem_q.size() > 0 && imem_q[0].due == cyc) begin
            bus_if.imem_rvalid = 1'b1;
            bus_if.imem_rdata  = word_of(imem_q[0].addr);
            imem_q.delete(0);
        end
        reset              = rst;
        bus_if.instr_ready = ready;
        bus_if.redirect    = redir;
        bus_if.redirect_pc = redir_pc;
        #1;
        s_req   = bus_if.imem_req;
        s_addr  = bus_if.imem_addr;
        s_valid = bus_if.instr_valid;
        s_instr = bus_if.instr;
        s_pc    = bus_if.instr_pc;
        if (s_req === 1'b1 && !rst) begin
            r.addr = s_addr;
            r.due  = cyc + lat;
            imem_q.push_back(r);
        end
        if (s_valid === 1'b1 && ready && !rst) begin
            acc_pc.push_back(s_pc);
            acc_instr.push_back(s_instr);
        end
        if (cyc >= 0 && cyc < NLOG) begin
            log_req[cyc]    = s_req;
            log_addr[cyc]   = s_addr;
            log_valid[cyc]  = s_valid;
            log_pc[cyc]     = s_pc;
            log_rvalid[cyc] = bus_if.imem_rvalid;
        end
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) cycle();
    endtask

    // Two reset cycles; cycle 0 is then the first cycle with reset low.
    task automatic do_reset(input int latency);
        rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; lat = latency;
        cycle();
        cycle();
        rst = 1'b0;
        cyc = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 32'h0; lat = 1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", s_req); end
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_valid); end
            checks++; if (s_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", s_instr); end
            checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", s_pc); end
        end
        rst = 1'b0; cyc = 0; clear_logs();
        cycle();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=00000000", s_req, s_addr);
        end
    endtask

    task automatic test_stream();
        int first;
        do_reset(1); ready = 1'b1;
        run_to(16);
        for (int k = 0; k < 16; k++) begin
            checks++; if (log_req[k] !== 1'b1 || log_addr[k] !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_req[%0d]: got req=%b addr=%h want req=1 addr=%h", k, log_req[k], log_addr[k], 32'(4 * k));
            end
        end
        first = -1;
        for (int k = 15; k >= 0; k--) if (log_valid[k] === 1'b1) first = k;
        checks++; if (log_rvalid[1] !== 1'b1 || first != 1 + LAT0) begin
            errors++; $display("FAIL stream_latency: got rvalid@1=%b first valid cycle %0d want cycle %0d", log_rvalid[1], first, 1 + LAT0);
        end
        for (int k = 1 + LAT0; k < 16; k++) begin
            checks++; if (log_valid[k] !== 1'b1) begin errors++; $display("FAIL stream_bubble[%0d]: got valid=%b want 1", k, log_valid[k]); end
        end
        checks++; if (acc_pc.size() != 15 - LAT0) begin
            errors++; $display("FAIL stream_count: got %0d want %0d", acc_pc.size(), 15 - LAT0);
        end
        foreach (acc_pc[i]) begin
            checks++; if (acc_pc[i] !== 32'(4 * i) || acc_instr[i] !== word_of(32'(4 * i))) begin
                errors++; $display("FAIL stream_order[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, acc_pc[i], acc_instr[i], 32'(4 * i), word_of(32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1); ready = 1'b0;
        run_to(20);
        for (int k = 0; k < 20; k++) begin
            checks++; if (log_req[k] !== (k < 4) || (k < 4 && log_addr[k] !== 32'(4 * k))) begin
                errors++; $display("FAIL stall_req[%0d]: got req=%b addr=%h want req=%b addr=%h", k, log_req[k], log_addr[k], (k < 4), 32'(4 * k));
            end
        end
        for (int k = 1 + LAT0; k < 20; k++) begin
            checks++; if (log_valid[k] !== 1'b1 || log_pc[k] !== 32'h0) begin
                errors++; $display("FAIL stall_head[%0d]: got valid=%b pc=%h want valid=1 pc=00000000", k, log_valid[k], log_pc[k]);
            end
        end
        ready = 1'b1;
        run_to(28);
        checks++; if (log_req[20] !== 1'b0 || log_req[21] !== 1'b1 || log_addr[21] !== 32'h10) begin
            errors++; $display("FAIL stall_resume: got req20=%b req21=%b addr21=%h want 0 1 00000010", log_req[20], log_req[21], log_addr[21]);
        end
        checks++; if (acc_pc.size() != 8) begin errors++; $display("FAIL stall_pops: got %0d want 8", acc_pc.size()); end
        foreach (acc_pc[i]) begin
            checks++; if (acc_pc[i] !== 32'(4 * i) || acc_instr[i] !== word_of(32'(4 * i))) begin
                errors++; $display("FAIL stall_order[%0d]: got pc=%h instr=%h want pc=%h", i, acc_pc[i], acc_instr[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(3); ready = 1'b0;
        run_to(3);
        redir = 1'b1; redir_pc = 32'h43;   // low bits must be ignored
        cycle();
        redir = 1'b0; ready = 1'b1;
        run_to(16);
        for (int k = 0; k < 3; k++) begin
            checks++; if (log_req[k] !== 1'b1 || log_addr[k] !== 32'(4 * k)) begin
                errors++; $display("FAIL redir_pre_req[%0d]: got req=%b addr=%h want req=1 addr=%h", k, log_req[k], log_addr[k], 32'(4 * k));
            end
        end
        checks++; if (log_req[3] !== 1'b0) begin errors++; $display("FAIL redir_block_req: got %b want 0", log_req[3]); end
        checks++; if (log_req[4] !== 1'b1 || log_addr[4] !== 32'h40) begin
            errors++; $display("FAIL redir_target_req: got req=%b addr=%h want req=1 addr=00000040", log_req[4], log_addr[4]);
        end
        for (int k = 4; k < 7 + LAT0; k++) begin
            checks++; if (log_valid[k] !== 1'b0) begin errors++; $display("FAIL redir_dropped[%0d]: got valid=%b pc=%h want valid=0", k, log_valid[k], log_pc[k]); end
        end
        checks++; if (log_valid[7 + LAT0] !== 1'b1 || log_pc[7 + LAT0] !== 32'h40) begin
            errors++; $display("FAIL redir_first_valid: got valid=%b pc=%h want valid=1 pc=00000040", log_valid[7 + LAT0], log_pc[7 + LAT0]);
        end
        checks++; if (acc_pc.size() == 0) begin errors++; $display("FAIL redir_acc_count: got 0 want >0"); end
        foreach (acc_pc[i]) begin
            checks++; if (acc_pc[i] !== 32'h40 + 32'(4 * i) || acc_instr[i] !== word_of(32'h40 + 32'(4 * i))) begin
                errors++; $display("FAIL redir_order[%0d]: got pc=%h instr=%h want pc=%h", i, acc_pc[i], acc_instr[i], 32'h40 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset(3); ready = 1'b1;
        run_to(2);
        redir = 1'b1; redir_pc = 32'h80;
        cycle();
        redir_pc = 32'hC0;
        cycle();
        redir = 1'b0;
        run_to(16);
        checks++; if (log_req[2] !== 1'b0 || log_req[3] !== 1'b0) begin
            errors++; $display("FAIL b2b_block: got req2=%b req3=%b want 0 0", log_req[2], log_req[3]);
        end
        checks++; if (log_req[4] !== 1'b1 || log_addr[4] !== 32'hC0) begin
            errors++; $display("FAIL b2b_target: got req=%b addr=%h want req=1 addr=000000c0", log_req[4], log_addr[4]);
        end
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (log_req[k] === 1'b1 && (log_addr[k] === 32'h80 || log_addr[k] === 32'h84)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stale_req: got %0d requests to 0x80/0x84 want 0", bad); end
        checks++; if (acc_pc.size() == 0) begin errors++; $display("FAIL b2b_acc_count: got 0 want >0"); end
        foreach (acc_pc[i]) begin
            checks++; if (acc_pc[i] !== 32'hC0 + 32'(4 * i) || acc_instr[i] !== word_of(32'hC0 + 32'(4 * i))) begin
                errors++; $display("FAIL b2b_order[%0d]: got pc=%h instr=%h want pc=%h", i, acc_pc[i], acc_instr[i], 32'hC0 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_pop_redirect();
        logic [31:0] head5;
        int pre, seen;
        head5 = 32'(4 * (4 - LAT0));
        pre   = 5 - LAT0;
        do_reset(1); ready = 1'b1;
        run_to(5);
        redir = 1'b1; redir_pc = 32'h200;
        cycle();
        redir = 1'b0;
        run_to(14);
        checks++; if (log_valid[5] !== 1'b1 || log_pc[5] !== head5) begin
            errors++; $display("FAIL popredir_head: got valid=%b pc=%h want valid=1 pc=%h", log_valid[5], log_pc[5], head5);
        end
        for (int k = 6; k <= 6 + LAT0; k++) begin
            checks++; if (log_valid[k] !== 1'b0) begin errors++; $display("FAIL popredir_empty[%0d]: got valid=%b want 0", k, log_valid[k]); end
        end
        checks++; if (log_req[6] !== 1'b1 || log_addr[6] !== 32'h200) begin
            errors++; $display("FAIL popredir_req: got req=%b addr=%h want req=1 addr=00000200", log_req[6], log_addr[6]);
        end
        checks++; if (log_valid[7 + LAT0] !== 1'b1 || log_pc[7 + LAT0] !== 32'h200) begin
            errors++; $display("FAIL popredir_target: got valid=%b pc=%h want valid=1 pc=00000200", log_valid[7 + LAT0], log_pc[7 + LAT0]);
        end
        seen = 0;
        foreach (acc_pc[i]) if (acc_pc[i] === head5) seen++;
        checks++; if (seen != 1) begin errors++; $display("FAIL popredir_once: got %0d acceptances of %h want 1", seen, head5); end
        checks++; if (acc_pc.size() <= pre || acc_pc[pre - 1] !== head5 || acc_pc[pre] !== 32'h200) begin
            errors++; $display("FAIL popredir_seq: got %0d entries want last-old=%h then 00000200", acc_pc.size(), head5);
        end
    endtask

    task automatic test_reset_mid();
        int nreq, nrv;
        do_reset(2); ready = 1'b0;
        run_to(3);
        nreq = 0; nrv = 0;
        for (int k = 0; k < 3; k++) begin
            if (log_req[k] === 1'b1) nreq++;
            if (log_rvalid[k] === 1'b1) nrv++;
        end
        checks++; if (nreq - nrv != 2) begin errors++; $display("FAIL rstmid_inflight: got %0d outstanding want 2", nreq - nrv); end
        rst = 1'b1;
        cycle();
        checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got req=%b valid=%b want 0 0", s_req, s_valid);
        end
        do_reset(2); ready = 1'b1;
        run_to(8);
        checks++; if (log_req[0] !== 1'b1 || log_addr[0] !== 32'h0 || log_valid[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_restart: got req=%b addr=%h valid=%b want 1 00000000 0", log_req[0], log_addr[0], log_valid[0]);
        end
        checks++; if (acc_pc.size() == 0 || acc_pc[0] !== 32'h0) begin
            errors++; $display("FAIL rstmid_first_instr: got %0d entries want first pc 00000000", acc_pc.size());
        end
        foreach (acc_pc[i]) begin
            checks++; if (acc_pc[i] !== 32'(4 * i) || acc_instr[i] !== word_of(32'(4 * i))) begin
                errors++; $display("FAIL rstmid_order[%0d]: got pc=%h want %h", i, acc_pc[i], 32'(4 * i));
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        rst                = 1'b1;
        ready              = 1'b0;
        redir              = 1'b0;
        redir_pc           = 32'h0;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        bus_if.instr_ready = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        clear_logs();

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_pop_redirect();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
